axis_src_arb: RTL and testbench
===============================

Name: axis_src_arb

Overview:
- Frame-locked round-robin arbiter sharing one AXI-stream sink between NUM_SRC stream sources (LFSR stimulus generators, encoder test sources).
- Grant is held from first beat until `last`, so frames never interleave.
- Output is one registered pipeline stage carrying the granted source index.
- Over-length frames are truncated: `last` is forced at MAX_BEATS and an error pulse is raised.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
DATAW, 64, data width per beat
MAX_BEATS, 16, max beats per frame; beat MAX_BEATS is forced last (>=2)
SRCW, $clog2(NUM_SRC), width of source index (derived, localparam)

Ports:
clk  in  1  clock, all logic on rising edge
s_rst_n  in  1  reset, active-low, asynchronous assert, synchronous-to-clk deassert by upstream
s_vld  in  NUM_SRC  per-source valid
s_rdy  out  NUM_SRC  per-source ready
s_data  in  NUM_SRC*DATAW  per-source data, source i at [i*DATAW +: DATAW]
s_last  in  NUM_SRC  per-source end-of-frame
m_vld  out  1  output valid
m_rdy  in  1  output ready from sink
m_data  out  DATAW  output data
m_last  out  1  output end-of-frame (source last or forced)
m_src  out  SRCW  source index of current output beat
busy  out  1  a frame is locked (state LOCK)
trunc_err  out  1  one-cycle pulse when a frame is truncated
frame_cnt  out  16  completed frames counter, wraps 0xFFFF->0

Behaviour:
- Reset (async, s_rst_n=0): state=IDLE, rr_ptr=NUM_SRC-1, grant=0, beat_cnt=0, m_vld=0, m_data=0, m_last=0, m_src=0, s_rdy=0, busy=0, trunc_err=0, frame_cnt=0. Reset mid-frame discards the in-flight beat; no partial frame is resumed.
- Transfer on an input: s_vld[i]&s_rdy[i]. Transfer on the output: m_vld&m_rdy.
- Output register accept condition `acc` = !m_vld | m_rdy.
  - m_vld/m_data/m_last/m_src load only when acc.
  - m_vld holds with stable data while m_vld&!m_rdy.
- FSM IDLE:
  - s_rdy=0.
  - If any s_vld: grant = first set index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC. Go to LOCK next cycle.
  - Otherwise stay in IDLE.
- FSM LOCK:
  - s_rdy[grant]=acc; all other s_rdy=0; busy=1.
  - Each input transfer loads the output register: m_data=s_data[grant], m_src=grant, m_vld=1, beat_cnt++.
  - m_last = s_last[grant] | (beat_cnt==MAX_BEATS-1).
  - On a transfer with m_last: rr_ptr=grant, beat_cnt=0, frame_cnt++, state->IDLE.
  - If that transfer had s_last=0 (forced end): trunc_err=1 for exactly that cycle; the remaining beats of that source are arbitrated as a new frame.
- If acc and no input transfer: m_vld clears when m_rdy consumes the held beat.
- Latency: first s_vld to s_rdy high = 1 cycle (IDLE decision). Input transfer to m_vld = 1 cycle.
- Throughput:
  - Within a frame: 1 beat/cycle while m_rdy=1.
  - Between frames: one IDLE bubble cycle on the input side.
- Simultaneous requests: only the round-robin winner is served; losers keep s_vld and must hold data (AXI rule).
  - After source k finishes, priority order is k+1..k.
  - A single active source is re-granted after each bubble.
- A source dropping s_vld mid-frame while granted: grant stays locked; no timeout other than the beat limit.
- Single-beat frame (s_last on first beat): LOCK lasts one transfer, frame_cnt++.
- Backpressure on the last beat: the FSM leaves LOCK only when the last beat enters the output register, not when it leaves it.
- beat_cnt width: $clog2(MAX_BEATS+1).

Test Plan:
- Reset, all s_vld=0, m_rdy=1 -> m_vld=0, all s_rdy=0, frame_cnt=0, busy=0 for 20 cycles.
- Source 2 only, 4-beat frame data 0x10..0x13, m_rdy=1:
  - s_rdy[2] high 1 cycle after s_vld.
  - m_data 0x10..0x13 on consecutive cycles, m_src=2, m_last on 0x13.
  - frame_cnt=1.
- All 4 sources continuously valid, 2-beat frames -> grant order 0,1,2,3,0,...; no interleaving within a frame; frame_cnt=8 after 8 frames.
- Source 1 never asserts last, MAX_BEATS=16:
  - m_last forced on beat 16, trunc_err single pulse.
  - Next frame from source 1 follows after other requesters are served.
- m_rdy toggled 1,0,0,1 during a frame from source 3 -> m_data/m_last stable while m_vld&!m_rdy; no beat lost or duplicated; ordering preserved.
- s_rst_n asserted asynchronously mid-frame (between clock edges) -> m_vld, s_rdy, busy go 0 immediately. After release, arbitration restarts with source 0 having priority.

Source files
------------

// File: rtl/axis_src_arb_if.sv
// Shared stream bundle for the source arbiter: NUM_SRC input lanes plus the
// single merged output. The arbiter takes the slave view; whatever feeds the
// sources and sinks the output takes the master view.
interface axis_src_arb_if #(
   parameter int NUM_SRC = 4,
   parameter int DATAW   = 64
);
   localparam int SRCW = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]       s_vld;
   logic [NUM_SRC-1:0]       s_rdy;
   logic [NUM_SRC*DATAW-1:0] s_data;
   logic [NUM_SRC-1:0]       s_last;
   logic                     m_vld;
   logic                     m_rdy;
   logic [DATAW-1:0]         m_data;
   logic                     m_last;
   logic [SRCW-1:0]          m_src;

   modport slave (
      input  s_vld, s_data, s_last, m_rdy,
      output s_rdy, m_vld, m_data, m_last, m_src
   );

   modport master (
      output s_vld, s_data, s_last, m_rdy,
      input  s_rdy, m_vld, m_data, m_last, m_src
   );
endinterface

// File: rtl/axis_src_arb.sv
// Frame-locked round-robin arbiter merging NUM_SRC streams into one sink.
// A grant is held from the first beat until last (source or forced at
// MAX_BEATS), so frames never interleave. One registered output stage.
//
// state | meaning
// IDLE  | no frame locked; pick next requester after rr_ptr
// LOCK  | frame from grant in progress; only grant may transfer
module axis_src_arb #(
   parameter int NUM_SRC   = 4,
   parameter int DATAW     = 64,
   parameter int MAX_BEATS = 16
) (
   input  logic                clk,
   input  logic                s_rst_n,
   axis_src_arb_if.slave       bus,
   output logic                busy,
   output logic                trunc_err,
   output logic [15:0]         frame_cnt
);
   localparam int SRCW = $clog2(NUM_SRC);
   localparam int BCW  = $clog2(MAX_BEATS + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t             state_q, state_d;
   logic [SRCW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [SRCW-1:0]    grant_q, grant_d;
   logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
   logic               m_vld_q, m_vld_d;
   logic [DATAW-1:0]   m_data_q, m_data_d;
   logic               m_last_q, m_last_d;
   logic [SRCW-1:0]    m_src_q, m_src_d;
   logic               trunc_err_q, trunc_err_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;

   logic               acc;
   logic               xfer;
   logic               last_c;
   logic               found;
   logic [SRCW-1:0]    idx_c;
   logic [NUM_SRC-1:0] s_rdy_c;

   // State registers; reset drops any in-flight beat and partial frame.
   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= SRCW'(NUM_SRC - 1);
         grant_q     <= '0;
         beat_cnt_q  <= '0;
         m_vld_q     <= 1'b0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         m_src_q     <= '0;
         trunc_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         beat_cnt_q  <= beat_cnt_d;
         m_vld_q     <= m_vld_d;
         m_data_q    <= m_data_d;
         m_last_q    <= m_last_d;
         m_src_q     <= m_src_d;
         trunc_err_q <= trunc_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Arbitration, frame locking and output-register load.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      beat_cnt_d  = beat_cnt_q;
      m_vld_d     = m_vld_q;
      m_data_d    = m_data_q;
      m_last_d    = m_last_q;
      m_src_d     = m_src_q;
      trunc_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      s_rdy_c     = '0;
      found       = 1'b0;
      idx_c       = '0;
      xfer        = 1'b0;
      last_c      = 1'b0;
      acc         = !m_vld_q || bus.m_rdy;

      case (state_q)
         IDLE: begin
            // Search starts just after the last finished source.
            for (int i = 1; i <= NUM_SRC; i++) begin
               idx_c = SRCW'((int'(rr_ptr_q) + i) % NUM_SRC);
               if (!found && bus.s_vld[idx_c]) begin
                  found   = 1'b1;
                  grant_d = idx_c;
               end
            end
            if (found) state_d = LOCK;
            if (acc) m_vld_d = 1'b0;
         end
         LOCK: begin
            s_rdy_c[grant_q] = acc;
            xfer   = bus.s_vld[grant_q] && acc;
            last_c = bus.s_last[grant_q] || (beat_cnt_q == BCW'(MAX_BEATS - 1));
            if (xfer) begin
               m_vld_d  = 1'b1;
               m_data_d = bus.s_data[grant_q*DATAW +: DATAW];
               m_src_d  = grant_q;
               m_last_d = last_c;
               if (last_c) begin
                  // FSM leaves LOCK when the last beat enters the register.
                  rr_ptr_d    = grant_q;
                  beat_cnt_d  = '0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  trunc_err_d = !bus.s_last[grant_q];
                  state_d     = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BCW'(1);
               end
            end else if (acc) begin
               m_vld_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.s_rdy  = s_rdy_c;
   assign bus.m_vld  = m_vld_q;
   assign bus.m_data = m_data_q;
   assign bus.m_last = m_last_q;
   assign bus.m_src  = m_src_q;
   assign busy       = (state_q == LOCK);
   assign trunc_err  = trunc_err_q;
   assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_axis_src_arb.sv
// Directed bench for axis_src_arb: per-source beat queues feed the inputs,
// a negedge monitor logs accepted output beats, expected beats are hand-built.
module tb_axis_src_arb;
   localparam int NS = 4;
   localparam int DW = 64;
   localparam int MB = 16;

   logic        clk = 1'b0;
   logic        s_rst_n = 1'b0;
   logic        busy;
   logic        trunc_err;
   logic [15:0] frame_cnt;

   axis_src_arb_if #(.NUM_SRC(NS), .DATAW(DW)) bus ();

   axis_src_arb #(.NUM_SRC(NS), .DATAW(DW), .MAX_BEATS(MB)) dut (
      .clk       (clk),
      .s_rst_n   (s_rst_n),
      .bus       (bus),
      .busy      (busy),
      .trunc_err (trunc_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [1:0]  src;
      int          cyc;
   } beat_t;

   logic [63:0] dq[NS][$];
   logic        lq[NS][$];
   beat_t       log_q[$];
   int          cyc = 0;
   int          trunc_n = 0;
   logic [63:0] trunc_data = '0;
   int          stall_n = 0;
   int          stab_err = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int s, input logic [63:0] d, input logic l);
      dq[s].push_back(d);
      lq[s].push_back(l);
   endtask

   task automatic clear_q();
      for (int i = 0; i < NS; i++) begin
         dq[i].delete();
         lq[i].delete();
      end
   endtask

   task automatic do_reset();
      s_rst_n = 1'b0;
      clear_q();
      repeat (2) tick();
      s_rst_n = 1'b1;
      log_q.delete();
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      repeat (4) tick();
      chk({tag, "_nbeats"}, 64'(log_q.size()), 64'(n));
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [1:0] src,
                           input logic last, input logic [63:0] data);
      logic [63:0] obs;
      obs = 'x;
      if (idx < log_q.size()) obs = {log_q[idx].src, log_q[idx].last, log_q[idx].data[60:0]};
      chk($sformatf("%s_b%0d", tag, idx), obs, {src, last, data[60:0]});
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Source driver: pops beats that transferred, presents the next head.
   initial begin
      logic [NS-1:0] xm;
      bus.s_vld  = '0;
      bus.s_last = '0;
      bus.s_data = '0;
      forever begin
         @(negedge clk);
         xm = bus.s_vld & bus.s_rdy;
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin
            if (xm[i] && dq[i].size() > 0) begin
               void'(dq[i].pop_front());
               void'(lq[i].pop_front());
            end
            bus.s_vld[i]           = dq[i].size() > 0;
            bus.s_data[i*DW +: DW] = (dq[i].size() > 0) ? dq[i][0] : '0;
            bus.s_last[i]          = (lq[i].size() > 0) ? lq[i][0] : 1'b0;
         end
      end
   end

   // Output monitor: logs accepted beats, stall stability, truncation pulses.
   initial begin
      logic        pstall;
      logic [63:0] pd;
      logic        pl;
      logic [1:0]  ps;
      pstall = 1'b0;
      pd = '0;
      pl = 1'b0;
      ps = '0;
      forever begin
         @(negedge clk);
         if (pstall && !(bus.m_vld === 1'b1 && bus.m_data === pd &&
                         bus.m_last === pl && bus.m_src === ps)) stab_err++;
         pstall = (bus.m_vld === 1'b1) && (bus.m_rdy === 1'b0);
         if (pstall) stall_n++;
         pd = bus.m_data;
         pl = bus.m_last;
         ps = bus.m_src;
         if (bus.m_vld === 1'b1 && bus.m_rdy === 1'b1)
            log_q.push_back('{bus.m_data, bus.m_last, bus.m_src, cyc});
         if (trunc_err === 1'b1) begin
            trunc_n++;
            trunc_data = bus.m_data;
         end
      end
   end

   initial begin
      int k;
      int t0;
      int s0;
      int e0;
      logic [3:0] pat;

      bus.m_rdy = 1'b1;
      s_rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      s_rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst_idle", 64'({bus.m_vld, bus.s_rdy, busy, trunc_err, frame_cnt}), 64'd0);
      end

      // single source 2, four beats
      log_q.delete();
      for (int i = 0; i < 4; i++) push(2, 64'h10 + 64'(i), i == 3);
      tick();
      chk("t2_rdy_first", 64'({bus.s_vld[2], bus.s_rdy[2]}), 64'b10);
      tick();
      chk("t2_rdy_lat", 64'({bus.s_vld[2], bus.s_rdy[2], busy}), 64'b111);
      wait_beats("t2", 4, 20);
      for (int i = 0; i < 4; i++) chk_beat("t2", i, 2'd2, i == 3, 64'h10 + 64'(i));
      if (log_q.size() == 4)
         for (int i = 1; i < 4; i++) chk("t2_gap", 64'(log_q[i].cyc - log_q[i-1].cyc), 64'd1);
      chk("t2_fcnt", 64'(frame_cnt), 64'd1);
      chk("t2_busy", 64'(busy), 64'd0);

      // all four sources, two 2-beat frames each
      do_reset();
      for (int s = 0; s < NS; s++)
         for (int f = 0; f < 2; f++)
            for (int b = 0; b < 2; b++)
               push(s, 64'(s * 'h100 + f * 'h10 + b), b == 1);
      wait_beats("t3", 16, 80);
      for (int fr = 0; fr < 8; fr++)
         for (int b = 0; b < 2; b++)
            chk_beat("t3", fr * 2 + b, 2'(fr % 4), b == 1,
                     64'((fr % 4) * 'h100 + (fr / 4) * 'h10 + b));
      chk("t3_fcnt", 64'(frame_cnt), 64'd8);

      // source 1 overruns MAX_BEATS while source 3 waits
      log_q.delete();
      t0 = trunc_n;
      for (int i = 0; i < 20; i++) push(1, 64'h100 + 64'(i), i == 19);
      push(3, 64'h300, 1'b1);
      wait_beats("t4", 21, 100);
      for (int i = 0; i < 16; i++) chk_beat("t4", i, 2'd1, i == 15, 64'h100 + 64'(i));
      chk_beat("t4", 16, 2'd3, 1'b1, 64'h300);
      for (int j = 0; j < 4; j++) chk_beat("t4", 17 + j, 2'd1, j == 3, 64'h110 + 64'(j));
      chk("t4_trunc_n", 64'(trunc_n - t0), 64'd1);
      chk("t4_trunc_data", trunc_data, 64'h10F);
      chk("t4_fcnt", 64'(frame_cnt), 64'd11);

      // sink backpressure pattern 1,0,0,1 on a frame from source 3
      log_q.delete();
      s0 = stall_n;
      e0 = stab_err;
      for (int i = 0; i < 4; i++) push(3, 64'h30 + 64'(i), i == 3);
      pat = 4'b1001;
      k = 0;
      while (log_q.size() < 4 && k < 40) begin
         bus.m_rdy = pat[k % 4];
         tick();
         k++;
      end
      bus.m_rdy = 1'b1;
      wait_beats("t5", 4, 20);
      for (int i = 0; i < 4; i++) chk_beat("t5", i, 2'd3, i == 3, 64'h30 + 64'(i));
      chk("t5_stable", 64'(stab_err - e0), 64'd0);
      chk("t5_stalled", 64'(stall_n > s0), 64'd1);
      chk("t5_fcnt", 64'(frame_cnt), 64'd12);

      // asynchronous reset in the middle of a frame
      log_q.delete();
      for (int i = 0; i < 6; i++) push(2, 64'h60 + 64'(i), i == 5);
      k = 0;
      while (log_q.size() < 2 && k < 20) begin
         tick();
         k++;
      end
      chk("t6_pre", 64'({busy, bus.m_vld}), 64'b11);
      #1;
      s_rst_n = 1'b0;
      #1;
      chk("t6_async", 64'({bus.m_vld, bus.s_rdy, busy, frame_cnt}), 64'd0);
      clear_q();
      repeat (2) tick();
      s_rst_n = 1'b1;
      log_q.delete();
      push(3, 64'h73, 1'b1);
      push(0, 64'h70, 1'b1);
      wait_beats("t6", 2, 20);
      chk_beat("t6", 0, 2'd0, 1'b1, 64'h70);
      chk_beat("t6", 1, 2'd3, 1'b1, 64'h73);
      chk("t6_fcnt", 64'(frame_cnt), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
